move_writer: RTL and testbench
==============================

Name: move_writer

Overview:
- Owns the nine-cell board register and is the only block that writes it.
- Accepts player moves over a valid/ready handshake, rejects moves to occupied or out-of-range cells, alternates turns, and freezes the board when the game ends.
- Drives pos1..pos9 to the win logic and the board-full detector, which only read the board.
- Cell encoding: 2'b00 empty, 2'b01 player X, 2'b10 player O; 2'b11 is never produced.

Parameters:
- FIRST_PLAYER, 0, player who moves first after reset/clear (0 = X, 1 = O).
- TIMEOUT_CYCLES, 500, idle cycles in READY before the turn is forfeited; legal range 1..65535; used only with MOVE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous new-game request, highest priority after reset.
- game_over  input  1  level; win/draw detected by downstream logic.
- move_valid  input  1  move request valid.
- move_pos  input  4  target cell, 1..9 legal, all other values illegal.
- move_ready  output  1  block can accept a move this cycle.
- move_accept  output  1  one-cycle pulse: last move written.
- move_illegal  output  1  one-cycle pulse: last move rejected.
- turn  output  1  player to move (0 = X, 1 = O).
- move_count  output  4  number of occupied cells, 0..9.
- pos1..pos9  output  2 each  board cells (row-major, pos1 top-left).
- timeout  output  1  one-cycle pulse: turn forfeited (MOVE_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, async) sets:
  - pos1..pos9 = 00, turn = FIRST_PLAYER, move_count = 0.
  - move_accept, move_illegal and timeout = 0.
  - state = READY, move_ready = 1.
- All outputs are registered.
- The FSM has three states: READY, CHECK, LOCKED.
- READY:
  - move_ready = 1.
  - A handshake (move_valid & move_ready) at edge E0 latches move_pos and moves the FSM to CHECK.
  - If game_over = 1, go to LOCKED; the handshake is ignored.
- CHECK:
  - move_ready = 0.
  - At edge E1, if the latched position is in 1..9 and that cell is 00:
    - write 01 when turn = 0, or 10 when turn = 1;
    - toggle turn;
    - increment move_count;
    - pulse move_accept for the cycle after E1.
  - Otherwise:
    - leave board, turn and move_count unchanged;
    - pulse move_illegal for the cycle after E1.
  - Next state is LOCKED if move_count becomes 9 or game_over = 1; otherwise READY.
- Latency and throughput:
  - Handshake to updated board and pulse: 1 cycle.
  - Maximum throughput: one move per 2 cycles.
- LOCKED:
  - move_ready = 0; moves are ignored with no pulses.
  - The board holds its contents.
  - Only clear or reset exits LOCKED.
- Priority rules:
  - clear = 1 at any edge returns every output to its reset value (state READY) and aborts a pending CHECK; no accept or illegal pulse is produced.
  - clear and move_valid in the same cycle: clear wins and the move is dropped.
  - game_over rising while in CHECK: the CHECK completes normally, then the FSM goes to LOCKED.
- move_accept and move_illegal are never both high.
- move_count never exceeds 9 and never wraps.

Optional Feature:
- MOVE_TIMEOUT_EN defined:
  - A 16-bit idle counter counts cycles spent in READY without a handshake.
  - The counter resets on any handshake, on clear, and on entering READY.
  - When it reaches TIMEOUT_CYCLES, turn toggles, timeout pulses for one cycle, the counter restarts, and the board is unchanged.
  - Counting stops in CHECK and LOCKED.
- Not defined:
  - No counter is built and the timeout output is tied 0.

Test Plan:
- Reset then move_pos = 5 handshake -> next cycle pos5 = 01, move_accept = 1, turn = 1, move_count = 1; following cycle move_ready = 1.
- X at 5, then O at 5 -> move_illegal = 1, pos5 stays 01, turn stays 1, move_count stays 1.
- move_pos = 0 and move_pos = 12 -> move_illegal each time; board and counters unchanged.
- Nine legal moves in order 1..9 -> pos cells alternate 01/10 starting at 01, move_count = 9, move_ready = 0 (LOCKED); a tenth move_valid gives no pulse.
- game_over = 1 after 3 moves, then clear -> LOCKED, then all cells 00, turn = FIRST_PLAYER, move_count = 0, move_ready = 1; clear asserted together with move_valid -> move dropped.
- MOVE_TIMEOUT_EN with TIMEOUT_CYCLES = 4, no moves -> timeout pulses every 4 cycles in READY, turn toggles each time, board all 00.

Source files
------------

// File: rtl/move_writer.sv
// move_writer: sole owner of the nine-cell board; accepts, validates and commits player moves.
// Optional turn-forfeit timer is built only when MOVE_TIMEOUT_EN is defined.
`default_nettype none

module move_writer #(
  parameter int FIRST_PLAYER   = 0,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       game_over,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_illegal,
  output logic       turn,
  output logic [3:0] move_count,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       timeout
);

  localparam logic [1:0] ST_READY  = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic       FIRST_TURN = FIRST_PLAYER[0];

  logic [1:0]       state_q, state_d;
  logic [8:0][1:0]  board_q, board_d;
  logic             turn_q, turn_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       pos_q, pos_d;
  logic             ready_q, ready_d;
  logic             accept_q, accept_d;
  logic             illegal_q, illegal_d;
  logic             hit, cell_empty, lock_next;

`ifdef MOVE_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    count_d    = count_q;
    pos_d      = pos_q;
    ready_d    = ready_q;
    accept_d   = 1'b0;
    illegal_d  = 1'b0;
    hit        = 1'b0;
    cell_empty = 1'b0;
    lock_next  = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    idle_d     = idle_q;
    timeout_d  = 1'b0;
`endif

    // Out-of-range positions never match any cell, so they fall out as illegal.
    for (int i = 0; i < 9; i++) begin
      if (pos_q == 4'(i + 1)) begin
        hit        = 1'b1;
        cell_empty = (board_q[i] == 2'b00);
      end
    end

    if (clear) begin
      state_d = ST_READY;
      board_d = '0;
      turn_d  = FIRST_TURN;
      count_d = 4'd0;
      pos_d   = 4'd0;
      ready_d = 1'b1;
`ifdef MOVE_TIMEOUT_EN
      idle_d  = 16'd0;
`endif
    end else begin
      case (state_q)
        ST_READY: begin
          if (game_over) begin
            state_d = ST_LOCKED;
            ready_d = 1'b0;
`ifdef MOVE_TIMEOUT_EN
            idle_d  = 16'd0;
`endif
          end else if (move_valid && ready_q) begin
            pos_d   = move_pos;
            state_d = ST_CHECK;
            ready_d = 1'b0;
`ifdef MOVE_TIMEOUT_EN
            idle_d  = 16'd0;
`endif
          end else begin
`ifdef MOVE_TIMEOUT_EN
            if (idle_q >= IDLE_LAST) begin
              idle_d    = 16'd0;
              turn_d    = ~turn_q;
              timeout_d = 1'b1;
            end else begin
              idle_d = idle_q + 16'd1;
            end
`endif
          end
        end
        ST_CHECK: begin
          if (hit && cell_empty) begin
            for (int i = 0; i < 9; i++) begin
              if (pos_q == 4'(i + 1)) board_d[i] = turn_q ? 2'b10 : 2'b01;
            end
            turn_d    = ~turn_q;
            count_d   = count_q + 4'd1;
            accept_d  = 1'b1;
            lock_next = (count_q == 4'd8) || game_over;
          end else begin
            illegal_d = 1'b1;
            lock_next = game_over;
          end
          state_d = lock_next ? ST_LOCKED : ST_READY;
          ready_d = ~lock_next;
`ifdef MOVE_TIMEOUT_EN
          idle_d  = 16'd0;
`endif
        end
        ST_LOCKED: begin
          ready_d = 1'b0;
        end
        default: begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_READY;
      board_q   <= '0;
      turn_q    <= FIRST_TURN;
      count_q   <= 4'd0;
      pos_q     <= 4'd0;
      ready_q   <= 1'b1;
      accept_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      pos_q     <= pos_d;
      ready_q   <= ready_d;
      accept_q  <= accept_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Timer absent: the output is a constant zero that still references the parameter.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  assign move_ready   = ready_q;
  assign move_accept  = accept_q;
  assign move_illegal = illegal_q;
  assign turn         = turn_q;
  assign move_count   = count_q;
  assign pos1 = board_q[0];
  assign pos2 = board_q[1];
  assign pos3 = board_q[2];
  assign pos4 = board_q[3];
  assign pos5 = board_q[4];
  assign pos6 = board_q[5];
  assign pos7 = board_q[6];
  assign pos8 = board_q[7];
  assign pos9 = board_q[8];

endmodule

`default_nettype wire

// File: tb/tb_move_writer.sv
// tb_move_writer: table-driven directed vectors for move_writer plus an idle/timeout sequence.
`default_nettype none

module tb_move_writer;

`ifdef MOVE_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 500;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       game_over = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic       move_ready, move_accept, move_illegal, turn, timeout;
  logic [3:0] move_count;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;

  move_writer #(.FIRST_PLAYER(0), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .game_over(game_over),
    .move_valid(move_valid), .move_pos(move_pos), .move_ready(move_ready),
    .move_accept(move_accept), .move_illegal(move_illegal), .turn(turn),
    .move_count(move_count), .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4),
    .pos5(pos5), .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        clr;
    logic        go;
    logic        val;
    logic [3:0]  pos;
    logic        rdy;
    logic        acc;
    logic        ill;
    logic        trn;
    logic [3:0]  cnt;
    logic [17:0] brd;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Board after k moves played into cells 1..k, written as {pos9..pos1}.
  logic [17:0] brd_k [10] = '{18'h00000, 18'h00001, 18'h00009, 18'h00019, 18'h00099,
                              18'h00199, 18'h00999, 18'h01999, 18'h09999, 18'h19999};

  function automatic void v(logic clr, logic go, logic val, logic [3:0] pos,
                            logic rdy, logic acc, logic ill, logic trn,
                            logic [3:0] cnt, logic [17:0] brd);
    vec_t e;
    e.clr = clr; e.go = go; e.val = val; e.pos = pos;
    e.rdy = rdy; e.acc = acc; e.ill = ill; e.trn = trn;
    e.cnt = cnt; e.brd = brd; e.tmo = 1'b0;
    vecs.push_back(e);
  endfunction

  function automatic logic [26:0] observed();
    return {move_ready, move_accept, move_illegal, turn, move_count,
            pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1, timeout};
  endfunction

  task automatic check(string name, logic [26:0] exp);
    logic [26:0] act;
    act = observed();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/acc/ill/turn/cnt/board/tmo=%h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t e, string name);
    clear      = e.clr;
    game_over  = e.go;
    move_valid = e.val;
    move_pos   = e.pos;
    @(negedge clk);
    check(name, {e.rdy, e.acc, e.ill, e.trn, e.cnt, e.brd, e.tmo});
  endtask

  task automatic play(int n);
    for (int k = 1; k <= n; k++) begin
      v(0, 0, 1, 4'(k), 0, 0, 0, 1'((k - 1) % 2), 4'(k - 1), brd_k[k - 1]);
      v(0, 0, 0, 4'd0,  (k < 9), 1, 0, 1'(k % 2), 4'(k), brd_k[k]);
    end
  endtask

  initial begin
    v(0, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);      // reset state
    v(0, 0, 1, 4'd5,  0, 0, 0, 0, 4'd0, 18'h0);      // X to 5, CHECK
    v(0, 0, 0, 4'd0,  1, 1, 0, 1, 4'd1, 18'h00100);  // accepted
    v(0, 0, 1, 4'd5,  0, 0, 0, 1, 4'd1, 18'h00100);  // O to occupied 5
    v(0, 0, 0, 4'd0,  1, 0, 1, 1, 4'd1, 18'h00100);
    v(0, 0, 1, 4'd0,  0, 0, 0, 1, 4'd1, 18'h00100);  // position 0
    v(0, 0, 0, 4'd0,  1, 0, 1, 1, 4'd1, 18'h00100);
    v(0, 0, 1, 4'd12, 0, 0, 0, 1, 4'd1, 18'h00100);  // position 12
    v(0, 0, 0, 4'd0,  1, 0, 1, 1, 4'd1, 18'h00100);
    v(1, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);      // clear
    play(9);
    v(0, 0, 1, 4'd1,  0, 0, 0, 1, 4'd9, 18'h19999);  // tenth move ignored
    v(0, 0, 0, 4'd0,  0, 0, 0, 1, 4'd9, 18'h19999);
    v(1, 0, 1, 4'd1,  1, 0, 0, 0, 4'd0, 18'h0);      // clear beats move
    v(0, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);
    play(3);
    v(0, 1, 0, 4'd0,  0, 0, 0, 1, 4'd3, 18'h00019);  // game_over locks
    v(0, 1, 1, 4'd4,  0, 0, 0, 1, 4'd3, 18'h00019);
    v(0, 0, 1, 4'd4,  0, 0, 0, 1, 4'd3, 18'h00019);  // stays locked
    v(1, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);
    v(0, 0, 1, 4'd4,  0, 0, 0, 0, 4'd0, 18'h0);      // game_over during CHECK
    v(0, 1, 0, 4'd0,  0, 1, 0, 1, 4'd1, 18'h00040);
    v(0, 0, 1, 4'd5,  0, 0, 0, 1, 4'd1, 18'h00040);
    v(1, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);
    v(0, 0, 1, 4'd2,  0, 0, 0, 0, 4'd0, 18'h0);      // clear aborts CHECK
    v(1, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);
    v(0, 0, 0, 4'd0,  1, 0, 0, 0, 4'd0, 18'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Idle in READY after a clear: forfeit every TO_CYC cycles when the timer exists.
    clear = 1'b1; game_over = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    @(negedge clk);
    clear = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      logic exp_tmo, exp_trn;
`ifdef MOVE_TIMEOUT_EN
      exp_tmo = (c % 4 == 0);
      exp_trn = 1'((c / 4) % 2);
`else
      exp_tmo = 1'b0;
      exp_trn = 1'b0;
`endif
      @(negedge clk);
      check($sformatf("idle%0d", c), {1'b1, 1'b0, 1'b0, exp_trn, 4'd0, 18'h0, exp_tmo});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
